// File: rtl/rc4_sched_if.sv
// rtl/rc4_sched_if.sv - phase handshakes, S-memory client ports and status of rc4_sched
// master = scheduler side, slave = datapath/memory side
interface rc4_sched_if #(
  parameter int KEY_WIDTH = 24
);
  logic                 start;
  logic                 init_start, ksa_start, prga_start;
  logic                 init_done, ksa_done, prga_done, prga_fail;
  logic [7:0]           init_address, init_data, ksa_address, ksa_data, prga_address, prga_data;
  logic                 init_wen, ksa_wen, prga_wen;
  logic [7:0]           s_address, s_data;
  logic                 s_wen;
  logic [KEY_WIDTH-1:0] secret_key;
  logic                 busy, key_found, search_fail, timeout;

  modport master (
    input  start, init_done, ksa_done, prga_done, prga_fail,
           init_address, init_data, init_wen, ksa_address, ksa_data, ksa_wen,
           prga_address, prga_data, prga_wen,
    output init_start, ksa_start, prga_start, s_address, s_data, s_wen,
           secret_key, busy, key_found, search_fail, timeout
  );

  modport slave (
    output start, init_done, ksa_done, prga_done, prga_fail,
           init_address, init_data, init_wen, ksa_address, ksa_data, ksa_wen,
           prga_address, prga_data, prga_wen,
    input  init_start, ksa_start, prga_start, s_address, s_data, s_wen,
           secret_key, busy, key_found, search_fail, timeout
  );
endinterface

// File: rtl/rc4_sched.sv
// rtl/rc4_sched.sv - RC4 key-search phase scheduler and single-port S-memory owner
// Optional per-phase watchdog (HUNG state, timeout flag): define RC4_SCHED_WATCHDOG_EN
module rc4_sched #(
  parameter int                   KEY_WIDTH      = 24,
  parameter logic [KEY_WIDTH-1:0] KEY_MAX        = 24'h3FFFFF,
  parameter int unsigned          TIMEOUT_CYCLES = 4096
) (
  input  logic        clk,
  input  logic        reset,
  rc4_sched_if.master bus
);

  typedef enum logic [3:0] {
    IDLE, INIT_GO, INIT_WAIT, KSA_GO, KSA_WAIT, PRGA_GO, PRGA_WAIT, FOUND, EXHAUSTED
`ifdef RC4_SCHED_WATCHDOG_EN
    , HUNG
`endif
  } state_t;

  state_t               state_q, state_d;
  logic [KEY_WIDTH-1:0] key_q;
  logic                 key_clr, key_inc;
  logic                 phase_done;

  // Only the done pulse of the phase being waited on is honoured
  assign phase_done = (state_q == INIT_WAIT && bus.init_done) ||
                      (state_q == KSA_WAIT  && bus.ksa_done)  ||
                      (state_q == PRGA_WAIT && bus.prga_done);

`ifdef RC4_SCHED_WATCHDOG_EN
  logic [12:0] wd_q;
  logic        in_wait;

  assign in_wait = (state_q == INIT_WAIT) || (state_q == KSA_WAIT) || (state_q == PRGA_WAIT);

  // Every GO cycle precedes its WAIT, so the count starts from zero on entry
  always_ff @(posedge clk) begin
    if (reset || !in_wait) wd_q <= '0;
    else                   wd_q <= wd_q + 13'd1;
  end
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      key_q   <= '0;
    end else begin
      state_q <= state_d;
      if (key_clr)      key_q <= '0;
      else if (key_inc) key_q <= key_q + KEY_WIDTH'(1);
    end
  end

  always_comb begin
    state_d = state_q;
    key_clr = 1'b0;
    key_inc = 1'b0;
    case (state_q)
      INIT_GO:   state_d = INIT_WAIT;
      INIT_WAIT: if (phase_done) state_d = KSA_GO;
      KSA_GO:    state_d = KSA_WAIT;
      KSA_WAIT:  if (phase_done) state_d = PRGA_GO;
      PRGA_GO:   state_d = PRGA_WAIT;
      PRGA_WAIT: begin
        if (phase_done) begin
          if (!bus.prga_fail) begin
            state_d = FOUND;
          end else if (key_q == KEY_MAX) begin
            state_d = EXHAUSTED;
          end else begin
            state_d = INIT_GO;
            key_inc = 1'b1;
          end
        end
      end
      default: begin
        if (bus.start) begin
          state_d = INIT_GO;
          key_clr = 1'b1;
        end
      end
    endcase
`ifdef RC4_SCHED_WATCHDOG_EN
    if (in_wait && !phase_done && wd_q == 13'(TIMEOUT_CYCLES - 1)) state_d = HUNG;
`endif
  end

  always_comb begin
    bus.s_address = 8'h00;
    bus.s_data    = 8'h00;
    bus.s_wen     = 1'b0;
    case (state_q)
      INIT_GO, INIT_WAIT: begin
        bus.s_address = bus.init_address;
        bus.s_data    = bus.init_data;
        bus.s_wen     = bus.init_wen;
      end
      KSA_GO, KSA_WAIT: begin
        bus.s_address = bus.ksa_address;
        bus.s_data    = bus.ksa_data;
        bus.s_wen     = bus.ksa_wen;
      end
      PRGA_GO, PRGA_WAIT: begin
        bus.s_address = bus.prga_address;
        bus.s_data    = bus.prga_data;
        bus.s_wen     = bus.prga_wen;
      end
      default: ;
    endcase
  end

  assign bus.init_start  = (state_q == INIT_GO);
  assign bus.ksa_start   = (state_q == KSA_GO);
  assign bus.prga_start  = (state_q == PRGA_GO);
  assign bus.busy        = (state_q == INIT_GO) || (state_q == INIT_WAIT) ||
                           (state_q == KSA_GO)  || (state_q == KSA_WAIT)  ||
                           (state_q == PRGA_GO) || (state_q == PRGA_WAIT);
  assign bus.key_found   = (state_q == FOUND);
  assign bus.search_fail = (state_q == EXHAUSTED);
  assign bus.secret_key  = key_q;

`ifdef RC4_SCHED_WATCHDOG_EN
  assign bus.timeout = (state_q == HUNG);
`else
  // Without the watchdog the limit has no effect and timeout never rises
  assign bus.timeout = 1'b0 & (TIMEOUT_CYCLES == 0);
`endif

endmodule
